// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for branch resolution: op encodings, default datapath
// width, the registered result record and the 2-bit counter step function.
package branch_predict_unit_pkg;

  // Default operand / PC width used by the predictor and the decoder.
  localparam int BPU_DATA_WIDTH = 32;

  // Branch op encodings as produced by the decoder.
  typedef enum logic [2:0] {
    OP_BEQ  = 3'b000,
    OP_BNE  = 3'b001,
    OP_JAL  = 3'b010,
    OP_RSVD = 3'b011,
    OP_BLT  = 3'b100,
    OP_BGE  = 3'b101,
    OP_BLTU = 3'b110,
    OP_BGEU = 3'b111
  } br_op_e;

  // Weakly not-taken: the state every BHT entry starts in.
  localparam logic [1:0] BHT_INIT = 2'b01;

  // Registered resolution result.
  typedef struct packed {
    logic valid;
    logic take;
    logic mispredict;
  } res_out_t;

  // True for ops that train the BHT (conditional branches only).
  function automatic logic is_conditional(input logic [2:0] op);
    return (op != OP_JAL) && (op != OP_RSVD);
  endfunction

  // Saturating 2-bit counter step: +1 when taken, -1 when not taken.
  function automatic logic [1:0] bht_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) nxt = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_unit_cond.sv
// Combinational branch condition evaluation for every branch op.
module branch_cond
  import branch_predict_unit_pkg::*;
#(
  parameter int DATA_WIDTH = BPU_DATA_WIDTH
) (
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_cond
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (i_a == i_b);
  assign w_lt_s = ($signed(i_a) < $signed(i_b));
  assign w_lt_u = (i_a < i_b);

  // Select the compare result for the op; jumps are always taken and the
  // reserved encoding is never taken.
  always_comb begin
    o_cond = 1'b0;
    case (i_op)
      OP_BEQ:  o_cond = w_eq;
      OP_BNE:  o_cond = ~w_eq;
      OP_JAL:  o_cond = 1'b1;
      OP_BLT:  o_cond = w_lt_s;
      OP_BGE:  o_cond = ~w_lt_s;
      OP_BLTU: o_cond = w_lt_u;
      OP_BGEU: o_cond = ~w_lt_u;
      default: o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: a table of 2-bit saturating counters read combinationally
// at fetch and trained at resolution, plus the registered resolution result
// and branch / mispredict statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int DATA_WIDTH = BPU_DATA_WIDTH,
  parameter int BHT_DEPTH  = 64,
  parameter int INDEX_LSB  = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_pred_pc,
  output logic                  o_pred_taken,
  input  logic                  i_res_valid,
  input  logic                  i_res_branch,
  input  logic [2:0]            i_res_op,
  input  logic [DATA_WIDTH-1:0] i_res_pc,
  input  logic [DATA_WIDTH-1:0] i_res_a,
  input  logic [DATA_WIDTH-1:0] i_res_b,
  input  logic                  i_res_pred_taken,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic                  o_take,
  output logic                  o_mispredict,
  output logic [CNT_WIDTH-1:0]  o_branch_cnt,
  output logic [CNT_WIDTH-1:0]  o_mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  // Counter table; the whole table must reset to weakly not-taken, so it is
  // held in flops rather than a RAM.
  logic [1:0] r_bht [BHT_DEPTH];

  logic [IDX_W-1:0]     w_pred_idx;
  logic [IDX_W-1:0]     w_res_idx;
  logic                 w_cond;
  logic                 w_outcome;
  logic                 w_accept;
  logic                 w_mispredict;
  logic                 w_bht_upd;
  logic [1:0]           w_bht_cur;
  logic [1:0]           w_bht_next;
  res_out_t             r_out;
  res_out_t             w_out_next;
  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_mispred_cnt;

  assign w_pred_idx = i_pred_pc[INDEX_LSB +: IDX_W];
  assign w_res_idx  = i_res_pc[INDEX_LSB +: IDX_W];

  // Read the table before any same-cycle write lands, so a colliding update
  // is only visible from the next cycle on.
  assign o_pred_taken = r_bht[w_pred_idx][1];

  branch_cond #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cond (
    .i_op  (i_res_op),
    .i_a   (i_res_a),
    .i_b   (i_res_b),
    .o_cond(w_cond)
  );

  // A non-branch instruction never counts as taken.
  assign w_outcome    = i_res_branch & w_cond;
  assign w_accept     = i_res_valid & ~i_flush;
  assign w_mispredict = w_outcome ^ i_res_pred_taken;

  // Only accepted conditional branches train the table.
  assign w_bht_upd  = w_accept & i_res_branch & is_conditional(i_res_op);
  assign w_bht_cur  = r_bht[w_res_idx];
  assign w_bht_next = bht_step(w_bht_cur, w_outcome);

  // Build the next registered result; rejected cycles produce all zeros.
  always_comb begin
    w_out_next = '0;
    if (w_accept) begin
      w_out_next.valid      = 1'b1;
      w_out_next.take       = w_outcome;
      w_out_next.mispredict = w_mispredict;
    end
  end

  // Table update: reset all entries to weakly not-taken, else train one entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= BHT_INIT;
      end
    end else if (w_bht_upd) begin
      r_bht[w_res_idx] <= w_bht_next;
    end
  end

  // Registered resolution result with one-cycle latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_out_next;
    end
  end

  // Statistics counters; they wrap naturally at their width.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_accept) begin
      if (i_res_branch) r_branch_cnt  <= r_branch_cnt + 1'b1;
      if (w_mispredict) r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign o_valid       = r_out.valid;
  assign o_take        = r_out.take;
  assign o_mispredict  = r_out.mispredict;
  assign o_branch_cnt  = r_branch_cnt;
  assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and random stimulus for the branch predictor with a reference model
// of the counter table and statistics, and a queue of expected results.
module tb_branch_predict_unit;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_pred_pc;
  logic        o_pred_taken;
  logic        i_res_valid;
  logic        i_res_branch;
  logic [2:0]  i_res_op;
  logic [31:0] i_res_pc;
  logic [31:0] i_res_a;
  logic [31:0] i_res_b;
  logic        i_res_pred_taken;
  logic        i_flush;
  logic        o_valid;
  logic        o_take;
  logic        o_mispredict;
  logic [31:0] o_branch_cnt;
  logic [31:0] o_mispred_cnt;

  branch_predict_unit dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_pred_pc       (i_pred_pc),
    .o_pred_taken    (o_pred_taken),
    .i_res_valid     (i_res_valid),
    .i_res_branch    (i_res_branch),
    .i_res_op        (i_res_op),
    .i_res_pc        (i_res_pc),
    .i_res_a         (i_res_a),
    .i_res_b         (i_res_b),
    .i_res_pred_taken(i_res_pred_taken),
    .i_flush         (i_flush),
    .o_valid         (o_valid),
    .o_take          (o_take),
    .o_mispredict    (o_mispredict),
    .o_branch_cnt    (o_branch_cnt),
    .o_mispred_cnt   (o_mispred_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic v;
    logic t;
    logic m;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  m_bht [64];
  logic [31:0] m_br;
  logic [31:0] m_mp;
  int          passed = 0;
  int          total  = 0;

  function automatic logic [5:0] idx(input logic [31:0] pc);
    return pc[7:2];
  endfunction

  // Reference outcome for an op and operands.
  function automatic logic ref_outcome(input logic br, input logic [2:0] op,
                                       input logic [31:0] a, input logic [31:0] b);
    logic r;
    case (op)
      3'b000:  r = (a == b);
      3'b001:  r = (a != b);
      3'b010:  r = 1'b1;
      3'b100:  r = ($signed(a) < $signed(b));
      3'b101:  r = ($signed(a) >= $signed(b));
      3'b110:  r = (a < b);
      3'b111:  r = (a >= b);
      default: r = 1'b0;
    endcase
    return br & r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_br = 0;
    m_mp = 0;
  endtask

  // Pop the expected result for the edge just passed and compare everything.
  task automatic check_outputs(input logic [31:0] ppc);
    exp_t e;
    check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("o_valid", 32'(o_valid), 32'(e.v));
      check("o_take", 32'(o_take), 32'(e.t));
      check("o_mispredict", 32'(o_mispredict), 32'(e.m));
    end
    check("o_branch_cnt", o_branch_cnt, m_br);
    check("o_mispred_cnt", o_mispred_cnt, m_mp);
    check("pred_after", 32'(o_pred_taken), 32'(m_bht[idx(ppc)][1]));
  endtask

  // One resolution cycle. Called #1 after a rising edge.
  task automatic res(input logic v, input logic br, input logic [2:0] op,
                     input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                     input logic pred, input logic fl, input logic [31:0] ppc);
    logic out;
    logic acc;
    exp_t e;
    i_res_valid = v; i_res_branch = br; i_res_op = op; i_res_pc = pc;
    i_res_a = a; i_res_b = b; i_res_pred_taken = pred; i_flush = fl; i_pred_pc = ppc;
    #1;
    check("pred_before", 32'(o_pred_taken), 32'(m_bht[idx(ppc)][1]));
    out = ref_outcome(br, op, a, b);
    acc = v & ~fl;
    e.v = acc; e.t = acc & out; e.m = acc & (out != pred);
    exp_q.push_back(e);
    @(posedge i_clk); #1;
    if (acc) begin
      if (br) m_br = m_br + 1;
      if (out != pred) m_mp = m_mp + 1;
      if (br && op != 3'b010 && op != 3'b011) begin
        if (out && m_bht[idx(pc)] != 2'b11) m_bht[idx(pc)] = m_bht[idx(pc)] + 2'b01;
        if (!out && m_bht[idx(pc)] != 2'b00) m_bht[idx(pc)] = m_bht[idx(pc)] - 2'b01;
      end
    end
    $display("txn v=%0b br=%0b op=%0d pc=0x%0h a=0x%0h b=0x%0h pred=%0b fl=%0b -> valid=%0b take=%0b misp=%0b brc=%0d mpc=%0d",
             v, br, op, pc, a, b, pred, fl, o_valid, o_take, o_mispredict, o_branch_cnt, o_mispred_cnt);
    check_outputs(ppc);
  endtask

  // Reset cycle with a live resolution presented; it must be discarded.
  task automatic do_reset();
    exp_t e;
    i_rst = 1'b1;
    i_res_valid = 1'b1; i_res_branch = 1'b1; i_res_op = 3'b010; i_res_pc = 32'h40;
    i_res_a = 0; i_res_b = 0; i_res_pred_taken = 1'b0; i_flush = 1'b0; i_pred_pc = 32'h100;
    e = '0;
    exp_q.push_back(e);
    @(posedge i_clk); #1;
    model_reset();
    i_rst = 1'b0;
    i_res_valid = 1'b0;
    $display("txn reset -> valid=%0b brc=%0d mpc=%0d pred=%0b", o_valid, o_branch_cnt, o_mispred_cnt, o_pred_taken);
    check_outputs(32'h100);
  endtask

  initial begin
    i_rst = 1'b1; i_pred_pc = 32'h100; i_res_valid = 0; i_res_branch = 0; i_res_op = 0;
    i_res_pc = 0; i_res_a = 0; i_res_b = 0; i_res_pred_taken = 0; i_flush = 0;
    model_reset();
    @(posedge i_clk); #1;
    do_reset();
    check("reset_pred_0x100", 32'(o_pred_taken), 32'd0);
    check("reset_brc", o_branch_cnt, 32'd0);
    check("reset_mpc", o_mispred_cnt, 32'd0);

    // Signed BLT, mispredicted; entry 16 becomes 10.
    res(1, 1, 3'b100, 32'h40, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h40);
    check("blt_pred_0x40", 32'(o_pred_taken), 32'd1);
    check("blt_entry16", 32'(m_bht[16]), 32'd2);

    // Fresh reset, then four taken BEQ and one not-taken at 0x80.
    do_reset();
    for (int i = 0; i < 4; i++) res(1, 1, 3'b000, 32'h80, 32'd5, 32'd5, 1, 0, 32'h80);
    check("beq_sat_11", 32'(m_bht[idx(32'h80)]), 32'd3);
    res(1, 1, 3'b000, 32'h80, 32'd5, 32'd6, 1, 0, 32'h80);
    check("beq_back_10", 32'(m_bht[idx(32'h80)]), 32'd2);
    check("beq_pred_stays", 32'(o_pred_taken), 32'd1);
    check("beq_brc5", o_branch_cnt, 32'd5);

    // Flushed BGEU: nothing registered or counted.
    res(1, 1, 3'b111, 32'h84, 32'h1, 32'hFFFFFFFF, 0, 1, 32'h84);
    // Flush without valid.
    res(0, 1, 3'b000, 32'h84, 32'h1, 32'h1, 0, 1, 32'h84);
    // JAL with pred=0: taken, mispredict, no BHT change.
    res(1, 1, 3'b010, 32'h88, 32'h0, 32'h0, 0, 0, 32'h88);
    check("jal_bht", 32'(m_bht[idx(32'h88)]), 32'd1);
    // Read-before-write on index 3.
    res(1, 1, 3'b001, 32'hC, 32'h1, 32'h2, 0, 0, 32'hC);
    // Non-branch with pred=1, reserved op, signed vs unsigned differences.
    res(1, 0, 3'b000, 32'h10, 32'h3, 32'h3, 1, 0, 32'h10);
    res(1, 1, 3'b011, 32'h10, 32'h3, 32'h3, 1, 0, 32'h10);
    res(1, 1, 3'b101, 32'h14, 32'h80000000, 32'h1, 0, 0, 32'h14);
    res(1, 1, 3'b110, 32'h14, 32'h1, 32'h80000000, 1, 0, 32'h14);
    res(1, 1, 3'b111, 32'h18, 32'h0, 32'h0, 1, 0, 32'h18);
    // Saturate at 00.
    res(1, 1, 3'b001, 32'h20, 32'h7, 32'h7, 0, 0, 32'h20);
    res(1, 1, 3'b001, 32'h20, 32'h7, 32'h7, 0, 0, 32'h20);
    check("sat_00", 32'(m_bht[idx(32'h20)]), 32'd0);
    // Idle cycle.
    res(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 32'h20);

    // Random mix with colliding indices.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] pc, ppc, a, b;
      pc  = {$urandom_range(0, 3), 24'h0, 2'b00, 6'h0} | (32'($urandom_range(0, 7)) << 2);
      ppc = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 20);
      a   = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 3));
      b   = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 3));
      res(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 4) != 0),
          3'($urandom_range(0, 7)), pc, a, b, logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 5) == 0), ppc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
